game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Top-level game sequencer for pong: owns match state, scores and serve timing, and gates the
//  per-frame ball/paddle updates. Sits in board_top between the VGA timing block (frame tick)
//  and the ball/paddle datapath. It consumes miss events and issues update enables and ball resets.
// PARAMETERS
//  SCORE_W      4    width of each score counter
//  WIN_SCORE    9    score that ends the match (must be < 2**SCORE_W)
//  SERVE_FRAMES 60   frames the ball is held centred before each serve (>=1)
// PORTS
//  clk_i          in   1        system clock
//  rst_n_i        in   1        async active-low reset
//  frame_tick_i   in   1        1-cycle pulse at start of each frame (vertical blank)
//  start_btn_i    in   1        start button, already synchronised, level
//  miss_left_i    in   1        1-cycle pulse: ball passed left paddle (right player scores)
//  miss_right_i   in   1        1-cycle pulse: ball passed right paddle (left player scores)
//  pause_btn_i    in   1        pause button, synchronised level (ignored unless GAME_CTRL_PAUSE_EN)
//  ball_rst_o     out  1        hold ball at centre
//  ball_en_o      out  1        1-cycle pulse: advance ball one step
//  paddle_en_o    out  1        1-cycle pulse: advance paddles one step
//  serve_dir_o    out  1        0 = serve toward left, 1 = toward right
//  score_l_o      out  SCORE_W  left player score
//  score_r_o      out  SCORE_W  right player score
//  game_over_o    out  1        match finished
//  winner_o       out  1        0 = left, 1 = right; valid while game_over_o
//  state_o        out  3        current game_state_t, for debug/HUD
// BEHAVIOUR
//  Clock clk_i only; reset async, active-low on rst_n_i. Reset: state IDLE, scores 0, serve_dir_o 1,
//   ball_rst_o 1, ball_en_o/paddle_en_o/game_over_o/winner_o 0, serve counter 0.
//  Buttons: rising edge only; a held button acts once. Edge detector regs reset to 1 (no edge at release of reset).
//  FSM (registered outputs, 1-cycle latency from triggering input):
//   IDLE      : ball_rst_o=1, no enables. start edge -> SERVE, scores cleared, counter loaded.
//   SERVE     : ball_rst_o=1; paddle_en_o pulses on each frame_tick_i. Counter decrements per tick;
//               tick at counter==1 -> PLAY. Exactly SERVE_FRAMES ticks spent in SERVE.
//   PLAY      : ball_rst_o=0; each frame_tick_i -> ball_en_o and paddle_en_o pulse next cycle.
//               miss_left_i -> score_r+1, serve_dir_o=0 (toward scorer's opponent: loser serves receive);
//               miss_right_i -> score_l+1, serve_dir_o=1. Then -> POINT.
//               Both misses same cycle -> no score change, serve_dir_o toggles, -> POINT.
//               Miss coinciding with frame_tick_i: miss wins, no enable pulse.
//   POINT     : one cycle; if either score == WIN_SCORE -> GAME_OVER (winner_o set), else
//               counter loaded -> SERVE.
//   GAME_OVER : game_over_o=1, ball_rst_o=1, scores frozen. start edge -> SERVE with scores cleared.
//  Misses outside PLAY ignored. Scores saturate at WIN_SCORE (never wrap).
//  Enables are never asserted in IDLE/POINT/GAME_OVER. Reset mid-match returns to IDLE at once.
// CONFIGURATION
//  GAME_CTRL_PAUSE_EN defined: extra state PAUSED. pause edge in SERVE/PLAY -> PAUSED (enables
//   stop, ball_rst_o holds previous value, serve counter frozen); pause edge in PAUSED -> return
//   to saved state. Misses ignored while PAUSED. start edge in PAUSED ignored.
//  Undefined: pause_btn_i unused, PAUSED encoding absent; state_o never shows it.
// STRUCTURE
//  pong_pkg: typedef enum logic [2:0] game_state_t {IDLE, SERVE, PLAY, POINT, PAUSED, GAME_OVER};
//   default SCORE_W/WIN_SCORE/SERVE_FRAMES constants shared with HUD renderer.
//  Sub-module btn_edge (rising-edge detector, async reset), one instance per button.
//  Serve counter width $clog2(SERVE_FRAMES+1).
// TESTING
//  1 Reset then start edge, SERVE_FRAMES=4: exactly 4 frame ticks in SERVE (paddle_en pulses 4x,
//    ball_en 0), 5th tick gives ball_en_o pulse; ball_rst_o falls on entering PLAY.
//  2 PLAY, miss_right_i pulse -> score_l_o 0->1, serve_dir_o=1, state POINT then SERVE, ball_rst_o=1.
//  3 miss_left_i and miss_right_i same cycle -> scores unchanged, serve_dir_o toggled.
//  4 WIN_SCORE=3: three miss_left_i -> score_r_o=3, game_over_o=1, winner_o=1; further misses
//    and ticks produce no enables; start edge -> scores 0, SERVE.
//  5 rst_n_i low mid-PLAY with score 2:1 -> outputs at reset values immediately (no clock edge needed).
//  6 GAME_CTRL_PAUSE_EN: pause edge in SERVE with counter 3 -> 10 ticks no enables; pause edge
//    again -> exactly 3 more ticks then PLAY; held start/pause button acts once.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared pong game definitions: match-state encoding and default match constants
// (also consumed by the HUD renderer).
// Optional feature macro: GAME_CTRL_PAUSE_EN adds the PAUSED encoding.
package game_ctrl_pkg;

  localparam int unsigned SCORE_W_DEF      = 4;
  localparam int unsigned WIN_SCORE_DEF    = 9;
  localparam int unsigned SERVE_FRAMES_DEF = 60;

  // Explicit values keep GAME_OVER stable whether or not PAUSED exists.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
`ifdef GAME_CTRL_PAUSE_EN
    PAUSED    = 3'd4,
`endif
    GAME_OVER = 3'd5
  } game_state_t;

endpackage

// File: rtl/game_ctrl_if.sv
// Game controller bus: frame/button/miss inputs and ball/paddle/score outputs.
//  master : game_ctrl side (consumes events, drives enables/scores/state)
//  slave  : board side (VGA timing, buttons, ball/paddle datapath, HUD)
interface game_ctrl_if
  import game_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_W = SCORE_W_DEF
) ();

  logic               frame_tick_i;
  logic               start_btn_i;
  logic               miss_left_i;
  logic               miss_right_i;
  logic               pause_btn_i;
  logic               ball_rst_o;
  logic               ball_en_o;
  logic               paddle_en_o;
  logic               serve_dir_o;
  logic [SCORE_W-1:0] score_l_o;
  logic [SCORE_W-1:0] score_r_o;
  logic               game_over_o;
  logic               winner_o;
  logic [2:0]         state_o;

  modport master (
    input  frame_tick_i, start_btn_i, miss_left_i, miss_right_i, pause_btn_i,
    output ball_rst_o, ball_en_o, paddle_en_o, serve_dir_o,
           score_l_o, score_r_o, game_over_o, winner_o, state_o
  );

  modport slave (
    output frame_tick_i, start_btn_i, miss_left_i, miss_right_i, pause_btn_i,
    input  ball_rst_o, ball_en_o, paddle_en_o, serve_dir_o,
           score_l_o, score_r_o, game_over_o, winner_o, state_o
  );

endinterface

// File: rtl/game_ctrl_btn_edge.sv
// Rising-edge detector for an already-synchronised button level.
//  clk_i, rst_n_i : clock, async active-low reset
//  btn_i          : button level
//  rise_c_o       : combinational 1-cycle pulse on a 0->1 transition
// The history register resets to 1 so a button held through reset release
// does not register as a press.
module game_ctrl_btn_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic rise_c_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) prev_q <= 1'b1;
    else          prev_q <= btn_i;
  end

  assign rise_c_o = btn_i & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Pong match sequencer: owns match state, scores and serve timing, and gates
// per-frame ball/paddle updates.
//  clk_i, rst_n_i : clock, async active-low reset
//  bus (master)   : frame tick, start/pause buttons, miss pulses in;
//                   ball_rst/ball_en/paddle_en, serve_dir, scores,
//                   game_over/winner, state out (all registered)
// Optional feature macro: GAME_CTRL_PAUSE_EN (pause button and PAUSED state).
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_W      = SCORE_W_DEF,
  parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
  parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  game_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [SCORE_W-1:0] WIN_L    = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SERVE_FRAMES);

  game_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               serve_dir_q, serve_dir_d;
  logic               ball_rst_q, ball_rst_d;
  logic               ball_en_q, ball_en_d;
  logic               paddle_en_q, paddle_en_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;
  logic               start_rise_c;

  game_ctrl_btn_edge u_start_edge (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .btn_i    (bus.start_btn_i),
    .rise_c_o (start_rise_c)
  );

`ifdef GAME_CTRL_PAUSE_EN
  game_state_t saved_q, saved_d;
  logic        pause_rise_c;

  game_ctrl_btn_edge u_pause_edge (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .btn_i    (bus.pause_btn_i),
    .rise_c_o (pause_rise_c)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) saved_q <= IDLE;
    else          saved_q <= saved_d;
  end
`else
  logic unused_pause_c;
  assign unused_pause_c = bus.pause_btn_i;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    ball_en_d   = 1'b0;
    paddle_en_d = 1'b0;
`ifdef GAME_CTRL_PAUSE_EN
    saved_d     = saved_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_rise_c) begin
          state_d   = SERVE;
          cnt_d     = CNT_LOAD;
          score_l_d = '0;
          score_r_d = '0;
        end
      end

      SERVE: begin
`ifdef GAME_CTRL_PAUSE_EN
        if (pause_rise_c) begin
          state_d = PAUSED;
          saved_d = SERVE;
        end else
`endif
        if (bus.frame_tick_i) begin
          paddle_en_d = 1'b1;
          // Tick seen with counter at 1 is the last serve frame.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      PLAY: begin
`ifdef GAME_CTRL_PAUSE_EN
        if (pause_rise_c) begin
          state_d = PAUSED;
          saved_d = PLAY;
        end else
`endif
        // Misses take priority over a coincident frame tick.
        if (bus.miss_left_i && bus.miss_right_i) begin
          serve_dir_d = ~serve_dir_q;
          state_d     = POINT;
        end else if (bus.miss_left_i) begin
          score_r_d   = (score_r_q >= WIN_L) ? score_r_q : score_r_q + SCORE_W'(1);
          serve_dir_d = 1'b0;
          state_d     = POINT;
        end else if (bus.miss_right_i) begin
          score_l_d   = (score_l_q >= WIN_L) ? score_l_q : score_l_q + SCORE_W'(1);
          serve_dir_d = 1'b1;
          state_d     = POINT;
        end else if (bus.frame_tick_i) begin
          ball_en_d   = 1'b1;
          paddle_en_d = 1'b1;
        end
      end

      POINT: begin
        if ((score_l_q == WIN_L) || (score_r_q == WIN_L)) begin
          state_d  = GAME_OVER;
          winner_d = (score_r_q == WIN_L);
        end else begin
          state_d = SERVE;
          cnt_d   = CNT_LOAD;
        end
      end

      GAME_OVER: begin
        if (start_rise_c) begin
          state_d   = SERVE;
          cnt_d     = CNT_LOAD;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = 1'b0;
        end
      end

`ifdef GAME_CTRL_PAUSE_EN
      PAUSED: begin
        if (pause_rise_c) state_d = saved_q;
      end
`endif

      default: state_d = IDLE;
    endcase

    // Ball is released only in PLAY; a pause keeps whatever it was.
    ball_rst_d = (state_d != PLAY);
`ifdef GAME_CTRL_PAUSE_EN
    if (state_d == PAUSED) ball_rst_d = ball_rst_q;
`endif
    game_over_d = (state_d == GAME_OVER);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      serve_dir_q <= 1'b1;
      ball_rst_q  <= 1'b1;
      ball_en_q   <= 1'b0;
      paddle_en_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
      ball_rst_q  <= ball_rst_d;
      ball_en_q   <= ball_en_d;
      paddle_en_q <= paddle_en_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign bus.ball_rst_o  = ball_rst_q;
  assign bus.ball_en_o   = ball_en_q;
  assign bus.paddle_en_o = paddle_en_q;
  assign bus.serve_dir_o = serve_dir_q;
  assign bus.score_l_o   = score_l_q;
  assign bus.score_r_o   = score_r_q;
  assign bus.game_over_o = game_over_q;
  assign bus.winner_o    = winner_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with SERVE_FRAMES=4, WIN_SCORE=3.
module tb_game_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SERVE  = 3'd1;
  localparam logic [2:0] S_PLAY   = 3'd2;
  localparam logic [2:0] S_POINT  = 3'd3;
  localparam logic [2:0] S_PAUSED = 3'd4;
  localparam logic [2:0] S_GO     = 3'd5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  game_ctrl_if #(.SCORE_W(4)) bus ();

  game_ctrl #(.SCORE_W(4), .WIN_SCORE(3), .SERVE_FRAMES(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One-cycle frame tick; returns at the negedge after it was consumed.
  task automatic tick();
    @(negedge clk) bus.frame_tick_i = 1'b1;
    @(negedge clk) bus.frame_tick_i = 1'b0;
  endtask

  task automatic miss(input logic l, input logic r, input logic t);
    @(negedge clk);
    bus.miss_left_i = l; bus.miss_right_i = r; bus.frame_tick_i = t;
    @(negedge clk);
    bus.miss_left_i = 1'b0; bus.miss_right_i = 1'b0; bus.frame_tick_i = 1'b0;
  endtask

  task automatic press_start();
    @(negedge clk) bus.start_btn_i = 1'b1;
    @(negedge clk) bus.start_btn_i = 1'b0;
  endtask

  // From POINT (non-winning) through 4 serve ticks into PLAY.
  task automatic serve_to_play();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.state_o !== S_PLAY) begin
      errors++; $display("FAIL serve_to_play state: got %0d exp %0d", bus.state_o, S_PLAY);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.frame_tick_i = 1'b0; bus.start_btn_i = 1'b0; bus.pause_btn_i = 1'b0;
    bus.miss_left_i = 1'b0; bus.miss_right_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.state_o, bus.score_l_o, bus.score_r_o} !== {S_IDLE, 4'd0, 4'd0}) begin
      errors++; $display("FAIL reset state/scores: got %0d/%0d/%0d exp 0/0/0",
                         bus.state_o, bus.score_l_o, bus.score_r_o);
    end
    checks++;
    if ({bus.serve_dir_o, bus.ball_rst_o, bus.ball_en_o, bus.paddle_en_o, bus.game_over_o, bus.winner_o}
        !== 6'b110000) begin
      errors++; $display("FAIL reset flags: got %b exp 110000",
        {bus.serve_dir_o, bus.ball_rst_o, bus.ball_en_o, bus.paddle_en_o, bus.game_over_o, bus.winner_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
    tick();
    checks++;
    if ({bus.state_o, bus.paddle_en_o, bus.ball_en_o, bus.ball_rst_o} !== {S_IDLE, 3'b001}) begin
      errors++; $display("FAIL idle_tick: got st=%0d pe=%b be=%b br=%b exp st=0 pe=0 be=0 br=1",
                         bus.state_o, bus.paddle_en_o, bus.ball_en_o, bus.ball_rst_o);
    end
  endtask

  task automatic test_serve();
    press_start();
    checks++;
    if ({bus.state_o, bus.ball_rst_o} !== {S_SERVE, 1'b1}) begin
      errors++; $display("FAIL start_to_serve: got st=%0d br=%b exp st=1 br=1", bus.state_o, bus.ball_rst_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.paddle_en_o, bus.ball_en_o} !== 2'b10) begin
        errors++; $display("FAIL serve_en[%0d]: got pe=%b be=%b exp pe=1 be=0", i, bus.paddle_en_o, bus.ball_en_o);
      end
      checks++;
      if (bus.state_o !== ((i == 3) ? S_PLAY : S_SERVE)) begin
        errors++; $display("FAIL serve_state[%0d]: got %0d exp %0d", i, bus.state_o, (i == 3) ? S_PLAY : S_SERVE);
      end
    end
    checks++;
    if (bus.ball_rst_o !== 1'b0) begin
      errors++; $display("FAIL play_ball_rst: got %b exp 0", bus.ball_rst_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.paddle_en_o, bus.ball_en_o} !== 2'b00) begin
      errors++; $display("FAIL en_pulse_width: got pe=%b be=%b exp 0 0", bus.paddle_en_o, bus.ball_en_o);
    end
    tick();
    checks++;
    if ({bus.paddle_en_o, bus.ball_en_o} !== 2'b11) begin
      errors++; $display("FAIL play_en: got pe=%b be=%b exp 1 1", bus.paddle_en_o, bus.ball_en_o);
    end
  endtask

  task automatic test_point();
    miss(1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.score_l_o, bus.score_r_o, bus.serve_dir_o, bus.state_o, bus.ball_rst_o}
        !== {4'd1, 4'd0, 1'b1, S_POINT, 1'b1}) begin
      errors++; $display("FAIL miss_right: got l=%0d r=%0d dir=%b st=%0d br=%b exp l=1 r=0 dir=1 st=3 br=1",
        bus.score_l_o, bus.score_r_o, bus.serve_dir_o, bus.state_o, bus.ball_rst_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.state_o, bus.ball_rst_o} !== {S_SERVE, 1'b1}) begin
      errors++; $display("FAIL point_to_serve: got st=%0d br=%b exp st=1 br=1", bus.state_o, bus.ball_rst_o);
    end
    miss(1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.state_o, bus.score_r_o} !== {S_SERVE, 4'd0}) begin
      errors++; $display("FAIL miss_in_serve: got st=%0d r=%0d exp st=1 r=0", bus.state_o, bus.score_r_o);
    end
    serve_to_play();
  endtask

  task automatic test_miss_tick();
    miss(1'b1, 1'b0, 1'b1);
    checks++;
    if ({bus.ball_en_o, bus.paddle_en_o, bus.score_r_o, bus.serve_dir_o, bus.state_o}
        !== {2'b00, 4'd1, 1'b0, S_POINT}) begin
      errors++; $display("FAIL miss_with_tick: got be=%b pe=%b r=%0d dir=%b st=%0d exp 0 0 1 0 3",
        bus.ball_en_o, bus.paddle_en_o, bus.score_r_o, bus.serve_dir_o, bus.state_o);
    end
    serve_to_play();
  endtask

  task automatic test_both_miss();
    miss(1'b1, 1'b1, 1'b0);
    checks++;
    if ({bus.score_l_o, bus.score_r_o, bus.serve_dir_o, bus.state_o} !== {4'd1, 4'd1, 1'b1, S_POINT}) begin
      errors++; $display("FAIL both_miss: got l=%0d r=%0d dir=%b st=%0d exp l=1 r=1 dir=1 st=3",
        bus.score_l_o, bus.score_r_o, bus.serve_dir_o, bus.state_o);
    end
    serve_to_play();
  endtask

  task automatic test_reset_mid();
    miss(1'b0, 1'b1, 1'b0);
    serve_to_play();
    checks++;
    if ({bus.score_l_o, bus.score_r_o} !== {4'd2, 4'd1}) begin
      errors++; $display("FAIL pre_reset_score: got %0d:%0d exp 2:1", bus.score_l_o, bus.score_r_o);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.state_o, bus.score_l_o, bus.score_r_o, bus.serve_dir_o, bus.ball_rst_o,
         bus.ball_en_o, bus.paddle_en_o, bus.game_over_o, bus.winner_o}
        !== {S_IDLE, 4'd0, 4'd0, 6'b110000}) begin
      errors++; $display("FAIL async_reset: got st=%0d l=%0d r=%0d dir=%b br=%b exp st=0 l=0 r=0 dir=1 br=1",
        bus.state_o, bus.score_l_o, bus.score_r_o, bus.serve_dir_o, bus.ball_rst_o);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_game_over();
    press_start();
    serve_to_play();
    for (int k = 1; k <= 3; k++) begin
      miss(1'b1, 1'b0, 1'b0);
      checks++;
      if ({bus.score_r_o, bus.state_o} !== {4'(k), S_POINT}) begin
        errors++; $display("FAIL win_seq[%0d]: got r=%0d st=%0d exp r=%0d st=3", k, bus.score_r_o, bus.state_o, k);
      end
      if (k < 3) serve_to_play();
    end
    @(negedge clk);
    checks++;
    if ({bus.state_o, bus.game_over_o, bus.winner_o, bus.ball_rst_o} !== {S_GO, 3'b111}) begin
      errors++; $display("FAIL game_over: got st=%0d go=%b win=%b br=%b exp st=5 go=1 win=1 br=1",
        bus.state_o, bus.game_over_o, bus.winner_o, bus.ball_rst_o);
    end
    tick();
    checks++;
    if ({bus.ball_en_o, bus.paddle_en_o} !== 2'b00) begin
      errors++; $display("FAIL go_tick_en: got be=%b pe=%b exp 0 0", bus.ball_en_o, bus.paddle_en_o);
    end
    miss(1'b0, 1'b1, 1'b1);
    checks++;
    if ({bus.score_l_o, bus.score_r_o, bus.state_o, bus.ball_en_o, bus.paddle_en_o}
        !== {4'd0, 4'd3, S_GO, 2'b00}) begin
      errors++; $display("FAIL go_frozen: got l=%0d r=%0d st=%0d be=%b pe=%b exp 0 3 5 0 0",
        bus.score_l_o, bus.score_r_o, bus.state_o, bus.ball_en_o, bus.paddle_en_o);
    end
    @(negedge clk) bus.start_btn_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.state_o, bus.score_l_o, bus.score_r_o, bus.game_over_o, bus.winner_o}
        !== {S_SERVE, 4'd0, 4'd0, 2'b00}) begin
      errors++; $display("FAIL restart: got st=%0d l=%0d r=%0d go=%b win=%b exp 1 0 0 0 0",
        bus.state_o, bus.score_l_o, bus.score_r_o, bus.game_over_o, bus.winner_o);
    end
    bus.start_btn_i = 1'b0;
  endtask

`ifdef GAME_CTRL_PAUSE_EN
  task automatic test_pause();
    tick();
    @(negedge clk) bus.pause_btn_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.state_o, bus.ball_rst_o} !== {S_PAUSED, 1'b1}) begin
      errors++; $display("FAIL pause_enter: got st=%0d br=%b exp st=4 br=1", bus.state_o, bus.ball_rst_o);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus.state_o, bus.ball_en_o, bus.paddle_en_o} !== {S_PAUSED, 2'b00}) begin
        errors++; $display("FAIL paused_tick[%0d]: got st=%0d be=%b pe=%b exp 4 0 0",
          i, bus.state_o, bus.ball_en_o, bus.paddle_en_o);
      end
    end
    press_start();
    checks++;
    if (bus.state_o !== S_PAUSED) begin
      errors++; $display("FAIL start_in_pause: got %0d exp 4", bus.state_o);
    end
    @(negedge clk) bus.pause_btn_i = 1'b0;
    @(negedge clk) bus.pause_btn_i = 1'b1;
    @(negedge clk) bus.pause_btn_i = 1'b0;
    checks++;
    if (bus.state_o !== S_SERVE) begin
      errors++; $display("FAIL pause_resume: got %0d exp 1", bus.state_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.paddle_en_o, bus.state_o} !== {1'b1, (i == 2) ? S_PLAY : S_SERVE}) begin
        errors++; $display("FAIL resume_serve[%0d]: got pe=%b st=%0d exp pe=1 st=%0d",
          i, bus.paddle_en_o, bus.state_o, (i == 2) ? S_PLAY : S_SERVE);
      end
    end
    @(negedge clk) bus.pause_btn_i = 1'b1;
    @(negedge clk) bus.pause_btn_i = 1'b0;
    miss(1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.state_o, bus.ball_rst_o, bus.score_r_o} !== {S_PAUSED, 1'b0, 4'd0}) begin
      errors++; $display("FAIL pause_in_play: got st=%0d br=%b r=%0d exp 4 0 0",
        bus.state_o, bus.ball_rst_o, bus.score_r_o);
    end
    @(negedge clk) bus.pause_btn_i = 1'b1;
    @(negedge clk) bus.pause_btn_i = 1'b0;
    checks++;
    if ({bus.state_o, bus.ball_rst_o} !== {S_PLAY, 1'b0}) begin
      errors++; $display("FAIL resume_play: got st=%0d br=%b exp 2 0", bus.state_o, bus.ball_rst_o);
    end
  endtask
`else
  task automatic test_pause();
    @(negedge clk) bus.pause_btn_i = 1'b1;
    @(negedge clk) bus.pause_btn_i = 1'b0;
    checks++;
    if (bus.state_o !== S_SERVE) begin
      errors++; $display("FAIL pause_ignored: got %0d exp 1", bus.state_o);
    end
    tick();
    checks++;
    if ({bus.paddle_en_o, bus.state_o} !== {1'b1, S_SERVE}) begin
      errors++; $display("FAIL no_pause_tick: got pe=%b st=%0d exp 1 1", bus.paddle_en_o, bus.state_o);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_serve();
    test_point();
    test_miss_tick();
    test_both_miss();
    test_reset_mid();
    test_game_over();
    test_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
